imem_prefetch_buffer: RTL and testbench

IMEM_PREFETCH_BUFFER -- requirements
Module: imem_prefetch_buffer

---
 rtl/imem_prefetch_buffer.sv | 173 +++++++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer. It runs ahead of the core, fetching
// sequential words into a small FIFO of {word address, data} entries.
// A core fetch can be served three ways:
//   - hit:    the FIFO head matches the requested word.
//   - bypass: the FIFO is empty and the in-flight memory response is for that word.
//   - miss:   anything else. The FIFO is flushed and prefetch restarts at the
//             requested address.
// Memory handshake: mem_req/mem_addr are registered and held stable until
// mem_ready. A request completes in any cycle where mem_req=1 and mem_ready=1.
// Only one request is outstanding at a time.
module imem_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       imem_req,
   input  logic [31:0]                imem_addr,
   output logic [31:0]                imem_data,
   output logic                       imem_ready,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   input  logic [31:0]                mem_rdata,
   input  logic                       mem_ready,
   output logic [$clog2(DEPTH):0]     buf_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // IDLE: no request. REQ: requesting fetch_ptr.
   // DRAIN: waiting out a stale request whose response is thrown away.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]     fetch_ptr_q, fetch_ptr_d;
   logic            mem_req_q, mem_req_d;
   logic [31:0]     mem_addr_q, mem_addr_d;

   logic [29:0]     entry_addr_q [DEPTH];
   logic [31:0]     entry_data_q [DEPTH];

   logic [29:0]     head_addr;
   logic [31:0]     head_data;
   logic            hit;
   logic            bypass;
   logic            miss;
   logic            pop;
   logic            push;
   logic            complete;
   logic [CW-1:0]   count_after_pop;

   assign head_addr = entry_addr_q[rd_ptr_q];
   assign head_data = entry_data_q[rd_ptr_q];

   // Core-side decode: classify the fetch and drive the response combinationally.
   always_comb begin
      hit        = 1'b0;
      bypass     = 1'b0;
      miss       = 1'b0;
      imem_ready = 1'b0;
      imem_data  = 32'h0;
      if (imem_req) begin
         hit    = (count_q != '0) && (head_addr == imem_addr[31:2]);
         bypass = (count_q == '0) && (state_q == ST_REQ) && mem_ready &&
                  (mem_addr_q[31:2] == imem_addr[31:2]);
         miss   = !hit && !bypass;
      end
      if (hit) begin
         imem_ready = 1'b1;
         imem_data  = head_data;
      end else if (bypass) begin
         imem_ready = 1'b1;
         imem_data  = mem_rdata;
      end
   end

   // Next-state logic for the FIFO pointers, fetch pointer and request FSM.
   always_comb begin
      pop             = hit;
      count_after_pop = count_q - CW'(pop);
      complete        = (state_q == ST_REQ) && mem_ready;
      // Bypassed or redirected responses never enter the FIFO.
      push            = complete && !bypass && !miss && (count_after_pop < DEPTH_C);

      count_d     = count_after_pop + CW'(push);
      rd_ptr_d    = rd_ptr_q + AW'(pop);
      wr_ptr_d    = wr_ptr_q + AW'(push);
      fetch_ptr_d = fetch_ptr_q;
      state_d     = state_q;

      // Any completed REQ advances the fetch pointer, even when bypassed.
      // The 32-bit add wraps 0xFFFF_FFFC to 0.
      if (complete) begin
         fetch_ptr_d = fetch_ptr_q + 32'd4;
      end

      // A miss overrides everything: empty the FIFO and redirect.
      if (miss) begin
         count_d     = '0;
         rd_ptr_d    = wr_ptr_q;
         wr_ptr_d    = wr_ptr_q;
         fetch_ptr_d = imem_addr & 32'hFFFF_FFFC;
      end

      case (state_q)
         ST_IDLE: begin
            if (count_d < DEPTH_C) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (miss && !mem_ready) begin
               state_d = ST_DRAIN;
            end else if (mem_ready) begin
               state_d = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_ready) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // In DRAIN, keep presenting the stale address until memory answers it.
      mem_req_d  = (state_d != ST_IDLE);
      mem_addr_d = (state_d == ST_DRAIN) ? mem_addr_q : fetch_ptr_d;
   end

   // Control and pointer registers. Reset abandons any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fetch_ptr_q <= RESET_PC;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= RESET_PC;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fetch_ptr_q <= fetch_ptr_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   // FIFO storage. Contents beyond count_q are don't-care, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         entry_addr_q[wr_ptr_q] <= fetch_ptr_q[31:2];
         entry_data_q[wr_ptr_q] <= mem_rdata;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign buf_count = count_q;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench for imem_prefetch_buffer. The memory model returns
// addr ^ 0xC0DE_5A5A combinationally for the presented address.
// Inputs are driven 1 time unit after the rising edge. Combinational
// outputs are sampled 1 unit later, and registered outputs right after each edge.
module tb_imem_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [2:0]  buf_count;

   int total = 0;
   int bad   = 0;

   imem_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_ready (imem_ready),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .buf_count  (buf_count)
   );

   // Clock generation.
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_5A5A;
   endfunction

   assign mem_rdata = mem_word(mem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_req = 1'b0; imem_addr = 32'h0; mem_ready = 1'b0;
      #3;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      total++; if (buf_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", buf_count); end
      total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", imem_ready); end
      total++; if (imem_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", imem_data); end
      tick(); tick();
      rst = 1'b0; mem_ready = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rel_idle_mem_req got=%b exp=0", mem_req); end
   endtask

   task automatic test_prefetch();
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL pf_mem_req%0d got=%b exp=1", i, mem_req); end
         total++; if (mem_addr !== 32'(4 * i)) begin bad++; $display("FAIL pf_addr%0d got=%h exp=%h", i, mem_addr, 32'(4 * i)); end
         total++; if (buf_count !== 3'(i)) begin bad++; $display("FAIL pf_count%0d got=%0d exp=%0d", i, buf_count, i); end
      end
      tick();
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL pf_full_mem_req got=%b exp=0", mem_req); end
      total++; if (buf_count !== 3'd4) begin bad++; $display("FAIL pf_full_count got=%0d exp=4", buf_count); end
   endtask

   task automatic test_back_to_back_hits();
      imem_req = 1'b1; imem_addr = 32'h0;
      #1;
      total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL hit0_ready got=%b exp=1", imem_ready); end
      total++; if (imem_data !== mem_word(32'h0)) begin bad++; $display("FAIL hit0_data got=%h exp=%h", imem_data, mem_word(32'h0)); end
      tick();
      total++; if (buf_count !== 3'd3) begin bad++; $display("FAIL hit0_count got=%0d exp=3", buf_count); end
      total++; if (mem_addr !== 32'h10 || mem_req !== 1'b1) begin bad++; $display("FAIL refetch10 got=%h/%b exp=00000010/1", mem_addr, mem_req); end
      imem_addr = 32'h4;
      #1;
      total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL hit4_ready got=%b exp=1", imem_ready); end
      total++; if (imem_data !== mem_word(32'h4)) begin bad++; $display("FAIL hit4_data got=%h exp=%h", imem_data, mem_word(32'h4)); end
      tick();
      total++; if (buf_count !== 3'd3) begin bad++; $display("FAIL pushpop_count got=%0d exp=3", buf_count); end
      total++; if (mem_addr !== 32'h14) begin bad++; $display("FAIL refetch14 got=%h exp=00000014", mem_addr); end
      imem_req = 1'b0;
      tick();
      total++; if (mem_req !== 1'b0 || buf_count !== 3'd4) begin bad++; $display("FAIL refill got=%b/%0d exp=0/4", mem_req, buf_count); end
   endtask

   task automatic test_bypass();
      logic [31:0] hits [4];
      logic [31:0] byp  [3];
      hits[0] = 32'h8; hits[1] = 32'hC; hits[2] = 32'h10; hits[3] = 32'h14;
      byp[0] = 32'h18; byp[1] = 32'h1C; byp[2] = 32'h20;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         imem_req = 1'b1; imem_addr = hits[i];
         #1;
         total++; if (imem_ready !== 1'b1 || imem_data !== mem_word(hits[i])) begin bad++; $display("FAIL order_hit%0d got=%b/%h exp=1/%h", i, imem_ready, imem_data, mem_word(hits[i])); end
         tick();
         total++; if (buf_count !== 3'(3 - i)) begin bad++; $display("FAIL order_count%0d got=%0d exp=%0d", i, buf_count, 3 - i); end
      end
      total++; if (mem_addr !== 32'h18 || mem_req !== 1'b1) begin bad++; $display("FAIL pend18 got=%h/%b exp=00000018/1", mem_addr, mem_req); end
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         imem_addr = byp[i];
         #1;
         total++; if (imem_ready !== 1'b1 || imem_data !== mem_word(byp[i])) begin bad++; $display("FAIL bypass%0d got=%b/%h exp=1/%h", i, imem_ready, imem_data, mem_word(byp[i])); end
         tick();
         total++; if (buf_count !== 3'd0 || mem_addr !== byp[i] + 32'd4) begin bad++; $display("FAIL bypass_after%0d got=%0d/%h exp=0/%h", i, buf_count, mem_addr, byp[i] + 32'd4); end
      end
   endtask

   task automatic test_drain();
      imem_addr = 32'h8;
      #1;
      total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL miss8_ready got=%b exp=0", imem_ready); end
      tick();
      total++; if (mem_addr !== 32'h8 || buf_count !== 3'd0) begin bad++; $display("FAIL redirect8 got=%h/%0d exp=00000008/0", mem_addr, buf_count); end
      mem_ready = 1'b0; imem_addr = 32'h100;
      #1;
      total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL miss100_ready got=%b exp=0", imem_ready); end
      tick();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL drain_hold got=%b/%h exp=1/00000008", mem_req, mem_addr); end
      imem_req = 1'b0; mem_ready = 1'b1;
      tick();
      total++; if (mem_addr !== 32'h100 || buf_count !== 3'd0) begin bad++; $display("FAIL drain_done got=%h/%0d exp=00000100/0", mem_addr, buf_count); end
      for (int i = 1; i < 4; i++) begin
         tick();
         total++; if (buf_count !== 3'(i) || mem_addr !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL fill100_%0d got=%0d/%h exp=%0d/%h", i, buf_count, mem_addr, i, 32'h100 + 32'(4 * i)); end
      end
      tick();
      total++; if (mem_req !== 1'b0 || buf_count !== 3'd4) begin bad++; $display("FAIL fill100_full got=%b/%0d exp=0/4", mem_req, buf_count); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0; exp_a[2] = 32'h4;
      imem_req = 1'b1; imem_addr = 32'hFFFF_FFF8;
      #1;
      total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL wrap_miss_ready got=%b exp=0", imem_ready); end
      tick();
      total++; if (mem_addr !== 32'hFFFF_FFF8 || buf_count !== 3'd0) begin bad++; $display("FAIL wrap_start got=%h/%0d exp=fffffff8/0", mem_addr, buf_count); end
      imem_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (mem_addr !== exp_a[i] || buf_count !== 3'(i + 1)) begin bad++; $display("FAIL wrap_addr%0d got=%h/%0d exp=%h/%0d", i, mem_addr, buf_count, exp_a[i], i + 1); end
      end
      imem_req = 1'b1; imem_addr = 32'hFFFF_FFF8;
      #1;
      total++; if (imem_ready !== 1'b1 || imem_data !== mem_word(32'hFFFF_FFF8)) begin bad++; $display("FAIL wrap_hit got=%b/%h exp=1/%h", imem_ready, imem_data, mem_word(32'hFFFF_FFF8)); end
      tick();
      imem_req = 1'b0; mem_ready = 1'b0;
      total++; if (buf_count !== 3'd3 || mem_addr !== 32'h8) begin bad++; $display("FAIL wrap_after got=%0d/%h exp=3/00000008", buf_count, mem_addr); end
   endtask

   task automatic test_reset_mid();
      tick();
      total++; if (mem_req !== 1'b1 || buf_count !== 3'd3) begin bad++; $display("FAIL pre_rst got=%b/%0d exp=1/3", mem_req, buf_count); end
      #2;
      rst = 1'b1; mem_ready = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0 || buf_count !== 3'd0) begin bad++; $display("FAIL async_rst got=%b/%0d exp=0/0", mem_req, buf_count); end
      tick();
      rst = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst2_idle got=%b exp=0", mem_req); end
      tick();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || buf_count !== 3'd0) begin bad++; $display("FAIL restart got=%b/%h/%0d exp=1/00000000/0", mem_req, mem_addr, buf_count); end
      tick();
      total++; if (mem_addr !== 32'h4 || buf_count !== 3'd1) begin bad++; $display("FAIL restart2 got=%h/%0d exp=00000004/1", mem_addr, buf_count); end
   endtask

   // Test sequence; each scenario leaves the DUT in the state the next one expects.
   initial begin
      test_reset();
      test_prefetch();
      test_back_to_back_hits();
      test_bypass();
      test_drain();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
